// File: rtl/sm_pkg.sv
// sm_pkg: shared types for the stack-machine host loader and core.
// Rev 1.0
`default_nettype none

package sm_pkg;

  typedef enum logic [1:0] {
    CMD_CODE  = 2'b00,
    CMD_DATA  = 2'b01,
    CMD_START = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_KICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } ld_state_e;

endpackage

`default_nettype wire

// File: rtl/sm_sat_cnt.sv
// sm_sat_cnt: up-counter with synchronous clear that saturates at all-ones.
// Rev 1.0
`default_nettype none

module sm_sat_cnt #(
  parameter int WIDTH = 6,
  parameter int INIT  = 0
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_CLR,
  input  logic             i_EN,
  output logic [WIDTH-1:0] o_CNT,
  output logic             o_TERM
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      cnt_q <= WIDTH'(INIT);
    end else if (i_CLR) begin
      cnt_q <= WIDTH'(INIT);
    end else if (i_EN && !o_TERM) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_CNT  = cnt_q;
  assign o_TERM = &cnt_q;

endmodule

`default_nettype wire

// File: rtl/sm_loader.sv
// sm_loader: host stream loader, start sequencer and result reporter for the stack-machine core.
// Rev 1.0
`default_nettype none

module sm_loader
  import sm_pkg::*;
#(
  parameter int CODERAM_ADDR_WIDTH = 6,
  parameter int CODERAM_DATA_WIDTH = 21,
  parameter int DATARAM_ADDR_WIDTH = 6,
  parameter int DATARAM_DATA_WIDTH = 16,
  parameter int RESULT_WIDTH       = 16,
  parameter int TIMEOUT_WIDTH      = 16
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_S_VALID,
  output logic                          o_S_READY,
  input  logic [1:0]                    i_S_CMD,
  input  logic [CODERAM_DATA_WIDTH-1:0] i_S_DATA,
  output logic                          o_CODERAM_WE,
  output logic [CODERAM_ADDR_WIDTH-1:0] o_CODERAM_ADDR,
  output logic [CODERAM_DATA_WIDTH-1:0] o_CODERAM_DATA,
  output logic                          o_DATARAM_WE,
  output logic [DATARAM_ADDR_WIDTH-1:0] o_DATARAM_ADDR,
  output logic [DATARAM_DATA_WIDTH-1:0] o_DATARAM_DATA,
  output logic                          o_TB_WE,
  input  logic                          i_RDY,
  input  logic                          i_ERROR,
  input  logic [RESULT_WIDTH-1:0]       i_RESULT,
  output logic                          o_R_VALID,
  input  logic                          i_R_READY,
  output logic [RESULT_WIDTH-1:0]       o_R_RESULT,
  output logic                          o_R_ERROR,
  output logic                          o_R_TIMEOUT,
  output logic                          o_R_LOADERR,
  output logic                          o_BUSY
);

  ld_state_e state_q, state_d;
  cmd_e      w_cmd;
  logic      w_accept, w_clr_load, w_code_wr, w_data_wr, w_wd_clr, w_wd_term;
  logic      w_code_term, w_data_term, w_unused_wd;
  logic [CODERAM_ADDR_WIDTH-1:0] w_code_cnt;
  logic [DATARAM_ADDR_WIDTH-1:0] w_data_cnt;
  logic [TIMEOUT_WIDTH-1:0]      w_wd_cnt;

  logic s_ready_q, busy_q, tb_we_q, code_we_q, data_we_q;
  logic code_full_q, data_full_q, loaderr_q;
  logic r_valid_q, r_error_q, r_timeout_q, r_loaderr_q;
  logic [CODERAM_ADDR_WIDTH-1:0] code_addr_q;
  logic [CODERAM_DATA_WIDTH-1:0] code_wdata_q;
  logic [DATARAM_ADDR_WIDTH-1:0] data_addr_q;
  logic [DATARAM_DATA_WIDTH-1:0] data_wdata_q;
  logic [RESULT_WIDTH-1:0]       r_result_q;

  assign w_cmd      = cmd_e'(i_S_CMD);
  assign w_accept   = i_S_VALID && s_ready_q;
  assign w_code_wr  = w_accept && (w_cmd == CMD_CODE) && !code_full_q;
  assign w_data_wr  = w_accept && (w_cmd == CMD_DATA) && !data_full_q;
  assign w_clr_load = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  assign w_wd_clr   = (state_q != ST_WAIT);
  assign w_unused_wd = ^w_wd_cnt;

  // Data address 0 is the core's forwarding operand, so data loading starts at 1.
  sm_sat_cnt #(.WIDTH(CODERAM_ADDR_WIDTH), .INIT(0)) u_code_cnt (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_CLR(w_clr_load), .i_EN(w_code_wr),
    .o_CNT(w_code_cnt), .o_TERM(w_code_term)
  );

  sm_sat_cnt #(.WIDTH(DATARAM_ADDR_WIDTH), .INIT(1)) u_data_cnt (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_CLR(w_clr_load), .i_EN(w_data_wr),
    .o_CNT(w_data_cnt), .o_TERM(w_data_term)
  );

  sm_sat_cnt #(.WIDTH(TIMEOUT_WIDTH), .INIT(0)) u_wd_cnt (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_CLR(w_wd_clr), .i_EN(1'b1),
    .o_CNT(w_wd_cnt), .o_TERM(w_wd_term)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_cmd == CMD_CODE || w_cmd == CMD_DATA) state_d = ST_LOAD;
          else if (w_cmd == CMD_START)                state_d = ST_KICK;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          if (w_cmd == CMD_START)      state_d = ST_KICK;
          else if (w_cmd == CMD_ABORT) state_d = ST_IDLE;
        end
      end
      ST_KICK:   state_d = ST_WAIT;
      ST_WAIT:   if (i_RDY || w_wd_term) state_d = ST_REPORT;
      ST_REPORT: if (i_R_READY) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A word hitting the last address still writes; only later words of that type drop.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      code_full_q <= 1'b0;
      data_full_q <= 1'b0;
      loaderr_q   <= 1'b0;
    end else if (w_clr_load) begin
      code_full_q <= 1'b0;
      data_full_q <= 1'b0;
      loaderr_q   <= 1'b0;
    end else begin
      if (w_code_wr && w_code_term) code_full_q <= 1'b1;
      if (w_data_wr && w_data_term) data_full_q <= 1'b1;
      if (w_accept && ((w_cmd == CMD_CODE && code_full_q) || (w_cmd == CMD_DATA && data_full_q)))
        loaderr_q <= 1'b1;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      tb_we_q      <= 1'b0;
      code_we_q    <= 1'b0;
      code_addr_q  <= '0;
      code_wdata_q <= '0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
    end else begin
      s_ready_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      busy_q    <= (state_d != ST_IDLE);
      tb_we_q   <= (state_d == ST_LOAD) || (state_d == ST_KICK);
      code_we_q <= w_code_wr;
      data_we_q <= w_data_wr;
      if (w_code_wr) begin
        code_addr_q  <= w_code_cnt;
        code_wdata_q <= i_S_DATA;
      end
      if (w_data_wr) begin
        data_addr_q  <= w_data_cnt;
        data_wdata_q <= i_S_DATA[DATARAM_DATA_WIDTH-1:0];
      end
    end
  end

  // A core result arriving on the terminal watchdog count takes priority over the timeout.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_valid_q   <= 1'b0;
      r_result_q  <= '0;
      r_error_q   <= 1'b0;
      r_timeout_q <= 1'b0;
      r_loaderr_q <= 1'b0;
    end else if (state_q == ST_WAIT && state_d == ST_REPORT) begin
      r_valid_q   <= 1'b1;
      r_result_q  <= i_RDY ? i_RESULT : '0;
      r_error_q   <= i_RDY & i_ERROR;
      r_timeout_q <= ~i_RDY;
      r_loaderr_q <= loaderr_q;
    end else if (state_q == ST_REPORT && i_R_READY) begin
      r_valid_q   <= 1'b0;
      r_result_q  <= '0;
      r_error_q   <= 1'b0;
      r_timeout_q <= 1'b0;
      r_loaderr_q <= 1'b0;
    end
  end

  assign o_S_READY      = s_ready_q;
  assign o_BUSY         = busy_q;
  assign o_TB_WE        = tb_we_q;
  assign o_CODERAM_WE   = code_we_q;
  assign o_CODERAM_ADDR = code_addr_q;
  assign o_CODERAM_DATA = code_wdata_q;
  assign o_DATARAM_WE   = data_we_q;
  assign o_DATARAM_ADDR = data_addr_q;
  assign o_DATARAM_DATA = data_wdata_q;
  assign o_R_VALID      = r_valid_q;
  assign o_R_RESULT     = r_result_q;
  assign o_R_ERROR      = r_error_q;
  assign o_R_TIMEOUT    = r_timeout_q;
  assign o_R_LOADERR    = r_loaderr_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_loader.sv
// tb_sm_loader: randomized self-checking bench for sm_loader against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_sm_loader;

  localparam int CAW = 6, CDW = 21, DAW = 6, DDW = 16, RW = 16, TW = 4;
  localparam int CODE_SLOTS = 1 << CAW;
  localparam int DATA_SLOTS = (1 << DAW) - 1;
  localparam int WD_TERM    = (1 << TW) - 1;

  logic           clk = 1'b0, rst = 1'b1;
  logic           s_valid = 1'b0, rdy = 1'b0, core_err = 1'b0, r_ready = 1'b0;
  logic [1:0]     s_cmd = 2'b00;
  logic [CDW-1:0] s_data = '0;
  logic [RW-1:0]  core_res = '0;

  logic           o_S_READY, o_CODERAM_WE, o_DATARAM_WE, o_TB_WE, o_R_VALID;
  logic           o_R_ERROR, o_R_TIMEOUT, o_R_LOADERR, o_BUSY;
  logic [CAW-1:0] o_CODERAM_ADDR;
  logic [CDW-1:0] o_CODERAM_DATA;
  logic [DAW-1:0] o_DATARAM_ADDR;
  logic [DDW-1:0] o_DATARAM_DATA;
  logic [RW-1:0]  o_R_RESULT;

  int checks = 0, failures = 0;

  logic [CAW-1:0] mon_caddr[$];
  logic [CDW-1:0] mon_cdata[$];
  logic [DAW-1:0] mon_daddr[$];
  logic [DDW-1:0] mon_ddata[$];
  logic [CDW-1:0] job_code[$];
  logic [CDW-1:0] job_data[$];

  sm_loader #(
    .CODERAM_ADDR_WIDTH(CAW), .CODERAM_DATA_WIDTH(CDW), .DATARAM_ADDR_WIDTH(DAW),
    .DATARAM_DATA_WIDTH(DDW), .RESULT_WIDTH(RW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_S_VALID(s_valid), .o_S_READY(o_S_READY),
    .i_S_CMD(s_cmd), .i_S_DATA(s_data),
    .o_CODERAM_WE(o_CODERAM_WE), .o_CODERAM_ADDR(o_CODERAM_ADDR), .o_CODERAM_DATA(o_CODERAM_DATA),
    .o_DATARAM_WE(o_DATARAM_WE), .o_DATARAM_ADDR(o_DATARAM_ADDR), .o_DATARAM_DATA(o_DATARAM_DATA),
    .o_TB_WE(o_TB_WE), .i_RDY(rdy), .i_ERROR(core_err), .i_RESULT(core_res),
    .o_R_VALID(o_R_VALID), .i_R_READY(r_ready), .o_R_RESULT(o_R_RESULT),
    .o_R_ERROR(o_R_ERROR), .o_R_TIMEOUT(o_R_TIMEOUT), .o_R_LOADERR(o_R_LOADERR), .o_BUSY(o_BUSY)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_CODERAM_WE) begin
      mon_caddr.push_back(o_CODERAM_ADDR);
      mon_cdata.push_back(o_CODERAM_DATA);
    end
    if (o_DATARAM_WE) begin
      mon_daddr.push_back(o_DATARAM_ADDR);
      mon_ddata.push_back(o_DATARAM_DATA);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CDW-1:0] rnd_word();
    logic [31:0] t;
    t = $urandom;
    return t[CDW-1:0];
  endfunction

  // Present one stream word and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [1:0] c, input logic [CDW-1:0] d);
    int n;
    n = 0;
    s_valid = 1'b1; s_cmd = c; s_data = d;
    while (!o_S_READY && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("send_ready_bound", {31'd0, o_S_READY}, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = rnd_word();
  endtask

  task automatic clear_mon();
    mon_caddr.delete(); mon_cdata.delete(); mon_daddr.delete(); mon_ddata.delete();
  endtask

  // Load job_code/job_data, START, answer with i_RDY in WAIT cycle rdy_at (negative: never).
  task automatic run_job(input bit shuffle, input int rdy_at, input bit err,
                         input logic [RW-1:0] res, input int hold);
    int  ic, id, nc, nd, nwc, nwd;
    bit  pick_code, got_rdy, exp_le;
    logic [RW-1:0] exp_res;
    ic = 0; id = 0; nc = job_code.size(); nd = job_data.size();
    clear_mon();
    chk("idle_tbwe", {31'd0, o_TB_WE}, 32'd0);
    chk("idle_busy", {31'd0, o_BUSY}, 32'd0);
    while (ic < nc || id < nd) begin
      pick_code = (ic < nc) && (id >= nd || !shuffle || $urandom_range(0, 1) == 0);
      if (pick_code) begin send(2'b00, job_code[ic]); ic++; end
      else           begin send(2'b01, job_data[id]); id++; end
      chk("load_tbwe", {31'd0, o_TB_WE}, 32'd1);
    end
    send(2'b10, rnd_word());
    chk("kick_tbwe", {31'd0, o_TB_WE}, 32'd1);
    chk("kick_sready", {31'd0, o_S_READY}, 32'd0);
    @(posedge clk); #1;
    chk("wait_tbwe", {31'd0, o_TB_WE}, 32'd0);
    chk("wait_busy", {31'd0, o_BUSY}, 32'd1);
    got_rdy = (rdy_at >= 0) && (rdy_at <= WD_TERM);
    repeat (got_rdy ? rdy_at : WD_TERM) begin @(posedge clk); #1; end
    chk("pre_rvalid", {31'd0, o_R_VALID}, 32'd0);
    if (got_rdy) begin rdy = 1'b1; core_err = err; core_res = res; end
    @(posedge clk); #1;
    rdy = 1'b0; core_err = 1'b0; core_res = rnd_word();
    exp_res = got_rdy ? res : '0;
    exp_le  = (nc > CODE_SLOTS) || (nd > DATA_SLOTS);
    for (int i = 0; i <= hold; i++) begin
      chk("rep_valid",   {31'd0, o_R_VALID}, 32'd1);
      chk("rep_result",  {16'd0, o_R_RESULT}, {16'd0, exp_res});
      chk("rep_error",   {31'd0, o_R_ERROR}, {31'd0, got_rdy & err});
      chk("rep_timeout", {31'd0, o_R_TIMEOUT}, {31'd0, !got_rdy});
      chk("rep_loaderr", {31'd0, o_R_LOADERR}, {31'd0, exp_le});
      chk("rep_sready",  {31'd0, o_S_READY}, 32'd0);
      if (i < hold) begin
        rdy = $urandom_range(0, 1); core_err = 1'b1; core_res = rnd_word();
        @(posedge clk); #1;
      end
    end
    rdy = 1'b0; core_err = 1'b0;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    chk("post_rvalid", {31'd0, o_R_VALID}, 32'd0);
    chk("post_busy",   {31'd0, o_BUSY}, 32'd0);
    chk("post_sready", {31'd0, o_S_READY}, 32'd1);
    nwc = (nc < CODE_SLOTS) ? nc : CODE_SLOTS;
    nwd = (nd < DATA_SLOTS) ? nd : DATA_SLOTS;
    chk("code_wr_count", mon_caddr.size(), nwc);
    chk("data_wr_count", mon_daddr.size(), nwd);
    for (int i = 0; i < nwc && i < mon_caddr.size(); i++) begin
      chk("code_addr", {26'd0, mon_caddr[i]}, i);
      chk("code_data", {11'd0, mon_cdata[i]}, {11'd0, job_code[i]});
    end
    for (int i = 0; i < nwd && i < mon_daddr.size(); i++) begin
      chk("data_addr", {26'd0, mon_daddr[i]}, i + 1);
      chk("data_data", {16'd0, mon_ddata[i]}, {16'd0, job_data[i][DDW-1:0]});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sready", {31'd0, o_S_READY}, 32'd0);
    chk("rst_busy",   {31'd0, o_BUSY}, 32'd0);
    chk("rst_tbwe",   {31'd0, o_TB_WE}, 32'd0);
    chk("rst_rvalid", {31'd0, o_R_VALID}, 32'd0);
    chk("rst_cwe",    {31'd0, o_CODERAM_WE}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_sready", {31'd0, o_S_READY}, 32'd1);

    job_code = '{21'h040041, 21'h0C1082, 21'h1C0000};
    job_data = '{21'h000003, 21'h000002};
    run_job(1'b0, 2, 1'b0, 16'h0005, 3);

    job_code = '{21'h012345}; job_data.delete();
    run_job(1'b0, 0, 1'b1, 16'h7FFF, 0);

    job_code.delete(); job_data.delete();
    run_job(1'b0, -1, 1'b0, 16'h1234, 2);
    run_job(1'b0, WD_TERM, 1'b0, 16'hBEEF, 1);

    job_code.delete();
    for (int i = 0; i < CODE_SLOTS + 1; i++) job_code.push_back(rnd_word());
    run_job(1'b0, 1, 1'b0, 16'h0001, 0);
    job_code.delete(); job_data.delete();
    for (int i = 0; i < DATA_SLOTS + 1; i++) job_data.push_back(rnd_word());
    run_job(1'b0, 1, 1'b0, 16'h0002, 0);

    job_data.delete();
    job_code = '{21'h000111, 21'h000222, 21'h000333};
    run_job(1'b0, 3, 1'b0, 16'hA5A5, 10);

    clear_mon();
    send(2'b00, rnd_word());
    send(2'b00, rnd_word());
    send(2'b11, rnd_word());
    chk("abort_tbwe",   {31'd0, o_TB_WE}, 32'd0);
    chk("abort_busy",   {31'd0, o_BUSY}, 32'd0);
    chk("abort_sready", {31'd0, o_S_READY}, 32'd1);
    job_code = '{21'h0ABCDE, 21'h155555}; job_data = '{21'h00FFFF};
    run_job(1'b1, 4, 1'b0, 16'h4242, 1);

    for (int k = 0; k < 8; k++) begin
      job_code.delete(); job_data.delete();
      for (int i = 0; i < $urandom_range(0, 6); i++) job_code.push_back(rnd_word());
      for (int i = 0; i < $urandom_range(0, 6); i++) job_data.push_back(rnd_word());
      run_job(1'b1, ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, WD_TERM)),
              1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(0, 4)));
    end

    clear_mon();
    send(2'b00, rnd_word());
    send(2'b10, rnd_word());
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   {31'd0, o_BUSY}, 32'd0);
    chk("arst_tbwe",   {31'd0, o_TB_WE}, 32'd0);
    chk("arst_sready", {31'd0, o_S_READY}, 32'd0);
    chk("arst_rvalid", {31'd0, o_R_VALID}, 32'd0);
    chk("arst_cwe",    {31'd0, o_CODERAM_WE}, 32'd0);
    chk("arst_caddr",  {26'd0, o_CODERAM_ADDR}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdy = (i == 3);
      @(posedge clk); #1;
      chk("arst_no_beat", {31'd0, o_R_VALID}, 32'd0);
      chk("arst_idle",    {31'd0, o_BUSY}, 32'd0);
    end
    rdy = 1'b0;
    job_code = '{21'h000007}; job_data = '{21'h000009};
    run_job(1'b0, 5, 1'b0, 16'h0BAD, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm_loader.md
Name: sm_loader

Overview:
- Host-side front end that sits directly upstream of the stack-machine core.
- Accepts a command/word stream from the host over a valid/ready handshake. Writes program words into CODE RAM and operand words into DATA RAM.
- Drives the core's load-enable (TB_WE) start protocol, then waits for the core's RDY pulse. Returns RESULT/ERROR, plus loader status, as a single valid/ready result beat.

Parameters:
- CODERAM_ADDR_WIDTH, 6, CODE RAM address width
- CODERAM_DATA_WIDTH, 21, CODE RAM word width; also the stream data width
- DATARAM_ADDR_WIDTH, 6, DATA RAM address width
- DATARAM_DATA_WIDTH, 16, DATA RAM word width (taken from stream data LSBs)
- RESULT_WIDTH, 16, core result width
- TIMEOUT_WIDTH, 16, WAIT-state watchdog counter width

Ports:
- i_CLK  in  1  clock
- i_RST  in  1  asynchronous, active-high reset
- i_S_VALID  in  1  host word valid
- o_S_READY  out  1  loader can accept a word
- i_S_CMD  in  2  command: 00 code word, 01 data word, 10 START, 11 ABORT
- i_S_DATA  in  CODERAM_DATA_WIDTH  word payload (ignored for START/ABORT)
- o_CODERAM_WE  out  1  CODE RAM write strobe
- o_CODERAM_ADDR  out  CODERAM_ADDR_WIDTH  CODE RAM write address
- o_CODERAM_DATA  out  CODERAM_DATA_WIDTH  CODE RAM write data
- o_DATARAM_WE  out  1  DATA RAM write strobe
- o_DATARAM_ADDR  out  DATARAM_ADDR_WIDTH  DATA RAM write address
- o_DATARAM_DATA  out  DATARAM_DATA_WIDTH  DATA RAM write data
- o_TB_WE  out  1  core load-enable; high = core held in INIT
- i_RDY  in  1  core done, one-cycle pulse
- i_ERROR  in  1  core overflow error, valid with i_RDY
- i_RESULT  in  RESULT_WIDTH  core result, valid with i_RDY
- o_R_VALID  out  1  result beat valid
- i_R_READY  in  1  host accepts result beat
- o_R_RESULT  out  RESULT_WIDTH  captured result
- o_R_ERROR  out  1  captured core error
- o_R_TIMEOUT  out  1  watchdog expired before i_RDY
- o_R_LOADERR  out  1  words were dropped on address exhaustion
- o_BUSY  out  1  state is not IDLE

Behaviour:
- Reset: every output 0. State IDLE. Counters and flags cleared. RAM contents are not touched. Reset asserted mid-operation aborts immediately, with no result beat.
- Transfers: a transfer occurs when i_S_VALID & o_S_READY. o_S_READY = 1 in IDLE and LOAD only.
- Output timing: all outputs are registered. A RAM write strobe is a one-cycle pulse in the cycle after acceptance, with address and data valid in the same cycle.
- Counters:
  - code_addr starts at 0.
  - data_addr starts at 1, because address 0 is the core's forwarding operand and must never be written.
  - Each counter increments after each write.
  - At all-ones the last write is performed and the counter saturates.
  - Further words of that type are accepted but discarded, and sticky loaderr is set.
- FSM states: IDLE, LOAD, KICK, WAIT, REPORT.
  - IDLE:
    - code/data word -> write it, go to LOAD.
    - START -> go to KICK.
    - ABORT -> stay in IDLE.
    - Counters and loaderr are cleared on every entry to IDLE.
  - LOAD:
    - code/data word -> write it, stay in LOAD.
    - START -> go to KICK.
    - ABORT -> go to IDLE.
  - KICK: exactly one cycle, then go to WAIT.
  - WAIT:
    - Watchdog counts from 0 each cycle.
    - i_RDY -> capture i_RESULT and i_ERROR, timeout=0, go to REPORT.
    - Watchdog reaches all-ones without i_RDY -> result=0, error=0, timeout=1, go to REPORT.
    - i_RDY in the terminal-count cycle wins over timeout.
  - REPORT:
    - o_R_VALID = 1; all o_R_* outputs held stable until i_R_READY.
    - On handshake -> go to IDLE.
- o_TB_WE:
  - 1 from the cycle after the first accepted word in IDLE through the KICK cycle.
  - 0 in IDLE, WAIT and REPORT.
  - It is therefore high for at least one cycle before falling, which moves the core INIT -> RUN. START from IDLE still produces the one-cycle KICK pulse, re-running the resident program.
- Latency: i_RDY at cycle t -> o_R_VALID at cycle t+1.
- i_RDY/i_ERROR outside WAIT are ignored.
- Stream writes during WAIT/REPORT are impossible, because o_S_READY = 0.
- o_BUSY = (state != IDLE).

Decomposition:
- Package sm_pkg holds the following; the core's opcode localparams migrate there later:
  - cmd enum: CMD_CODE, CMD_DATA, CMD_START, CMD_ABORT.
  - Loader state enum.
- One sub-module, sm_sat_cnt: parameterised-width counter with clear, enable, saturating terminal flag. It is instantiated three times: code_addr, data_addr, watchdog.

Test Plan:
1. Basic run:
   - Stimulus: code words 0x040041, 0x0C1082, 0x1C0000; data words 0x0003, 0x0002; START; core pulses i_RDY with i_RESULT=0x0005.
   - Response: CODERAM writes at addresses 0,1,2; DATARAM writes at addresses 1,2; o_TB_WE high from the cycle after the first word through KICK; R beat with result 0x0005, error 0, timeout 0, loaderr 0.
2. Core error:
   - Stimulus: i_RDY with i_ERROR=1, i_RESULT=0x7FFF.
   - Response: o_R_ERROR=1, o_R_RESULT=0x7FFF, beat 1 cycle after i_RDY.
3. Watchdog:
   - Stimulus: TIMEOUT_WIDTH=4, START, no i_RDY.
   - Response: REPORT 15 cycles after WAIT entry, with timeout=1 and result 0x0000.
   - Stimulus: i_RDY in the terminal cycle.
   - Response: timeout=0.
4. Exhaustion:
   - Stimulus: 65 code words.
   - Response: only 64 writes, addresses 0..63; loaderr=1 in the beat.
   - Stimulus: 64 data words.
   - Response: writes at addresses 1..63 only; loaderr=1.
5. Handshake/abort:
   - Stimulus: hold i_R_READY low for 10 cycles.
   - Response: o_R_VALID and o_R_* stable, o_S_READY=0 throughout.
   - Stimulus: ABORT in LOAD.
   - Response: o_TB_WE=0 the next cycle; the next code word writes address 0.
6. Reset mid-WAIT:
   - Stimulus: i_RST=1 asynchronously.
   - Response: all outputs 0 immediately, state IDLE; no result beat after release.
